// File: rtl/divu_iter.sv
// Iterative unsigned divider (restoring division, one quotient bit per cycle).
// Optional DIVU_ITER_DIV0_FAST_EN: a zero divisor skips RUN and goes straight to DONE.
//
// state | meaning
// IDLE  | waiting for a request, o_ready=1
// RUN   | shifting/subtracting, one quotient bit per edge
// DONE  | result presented, o_valid=1, held until i_ready
module divu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] q_reg, r_reg, d_reg;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   sub;
    logic             borrow;
    logic             last_iter;
    logic             div0;

    // r_shift can exceed WIDTH bits, so the trial subtraction is WIDTH+1 wide.
    // A set r_shift MSB means r_shift >= 2^WIDTH > divisor, so no borrow.
    assign r_shift   = {r_reg, q_reg[WIDTH-1]};
    assign sub       = r_shift - {1'b0, d_reg};
    assign borrow    = sub[WIDTH] & ~r_shift[WIDTH];
    assign last_iter = (cnt == CW'(WIDTH - 1));
    assign div0      = (i_divisor == '0);

    assign o_ready     = (state == IDLE);
    assign o_valid     = (state == DONE);
    assign o_quotient  = q_reg;
    assign o_remainder = r_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (i_valid) begin
`ifdef DIVU_ITER_DIV0_FAST_EN
                    state_nx = div0 ? DONE : RUN;
`else
                    state_nx = RUN;
`endif
                end
            end
            RUN: begin
                if (last_iter) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (i_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
            r_reg <= '0;
            d_reg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
`ifdef DIVU_ITER_DIV0_FAST_EN
                        q_reg <= div0 ? '1 : i_dividend;
                        r_reg <= div0 ? i_dividend : '0;
`else
                        q_reg <= i_dividend;
                        r_reg <= '0;
`endif
                        d_reg <= i_divisor;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    q_reg <= {q_reg[WIDTH-2:0], ~borrow};
                    r_reg <= borrow ? r_shift[WIDTH-1:0] : sub[WIDTH-1:0];
                    cnt   <= cnt + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // div0 is only consumed when the fast zero-divisor path is built in.
    logic unused_div0;
    assign unused_div0 = div0;

endmodule
